// File: rtl/seizure_pkg.sv
// Shared types for the seizure-detection mean path: sample format and
// the window controller state encoding.
package seizure_pkg;

  localparam int EEG_W = 18;

  // Signed fixed-point sample, 1 sign bit, 5 integer bits, 12 fraction bits.
  typedef logic [EEG_W-1:0] q1_5_12_t;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DIV_ISSUE,
    DIV_WAIT,
    HOLD,
    ERR
  } mw_state_t;

endpackage

// File: rtl/mean_window_ctrl.sv
// Window sequencer in front of the mean stage. It forwards one window of
// samples as per-sample strobes, launches the divider once the last sample
// has landed in the sum, waits for completion (with a blanking period and a
// timeout), and presents the captured mean downstream on valid/ready.
module mean_window_ctrl
  import seizure_pkg::*;
#(
  parameter int WINDOW    = 256,
  parameter int BLANK_CYC = 2,
  parameter int TIMEOUT   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             epoch_start,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [EEG_W-1:0] s_eeg,
  output logic             mc_start,
  output logic [EEG_W-1:0] mc_eeg,
  output logic             mc_start_div,
  input  logic             mc_complete_div,
  input  logic [EEG_W-1:0] mc_mean,
  input  logic [7:0]       mc_count,
  output logic [EEG_W-1:0] mean_out,
  output logic             mean_valid,
  input  logic             mean_ready,
  output logic             busy,
  output logic             err_timeout,
  output logic             err_count
);

  localparam int CNT_W = $clog2(WINDOW) + 1;
  localparam int TMR_W = $clog2(BLANK_CYC + TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WINDOW - 1);
  localparam logic [7:0]       WIN_LOW8  = 8'(WINDOW);
  localparam logic [TMR_W-1:0] BLANK_END = TMR_W'(BLANK_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(BLANK_CYC + TIMEOUT - 1);

  mw_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TMR_W-1:0] tmr_q;
  logic             s_ready_q;
  logic             mc_start_q;
  q1_5_12_t         mc_eeg_q;
  logic             mc_start_div_q;
  q1_5_12_t         mean_out_q;
  logic             mean_valid_q;
  logic             err_timeout_q;
  logic             err_count_q;

  logic xfer;
  logic cpl_ok;

  assign xfer   = s_valid & s_ready_q;
  // The divider's complete flag may still be high from a previous run, so it
  // only counts once the blanking period after the launch has elapsed.
  assign cpl_ok = mc_complete_div && (tmr_q > BLANK_END);

  // Sequencer FSM with its sample counter, blank/timeout timer and all
  // registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      tmr_q          <= '0;
      s_ready_q      <= 1'b0;
      mc_start_q     <= 1'b0;
      mc_eeg_q       <= '0;
      mc_start_div_q <= 1'b0;
      mean_out_q     <= '0;
      mean_valid_q   <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_count_q    <= 1'b0;
    end else begin
      mc_start_q     <= 1'b0;
      mc_start_div_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (epoch_start) begin
            cnt_q     <= '0;
            s_ready_q <= 1'b1;
            state_q   <= ACCUM;
          end
        end
        ACCUM: begin
          if (xfer) begin
            mc_start_q <= 1'b1;
            mc_eeg_q   <= s_eeg;
            cnt_q      <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              s_ready_q <= 1'b0;
              state_q   <= DIV_ISSUE;
            end
          end
        end
        // One cycle here lets the last strobe reach the mean stage sum
        // before the divider is launched.
        DIV_ISSUE: begin
          mc_start_div_q <= 1'b1;
          tmr_q          <= '0;
          state_q        <= DIV_WAIT;
        end
        DIV_WAIT: begin
          tmr_q <= tmr_q + 1'b1;
          // The mean stage count has absorbed every strobe by launch time.
          if (mc_start_div_q && (mc_count != WIN_LOW8)) begin
            err_count_q <= 1'b1;
          end
          if (cpl_ok) begin
            mean_out_q   <= mc_mean;
            mean_valid_q <= 1'b1;
            state_q      <= HOLD;
          end else if (tmr_q == TMR_LAST) begin
            err_timeout_q <= 1'b1;
            state_q       <= ERR;
          end
        end
        HOLD: begin
          if (mean_valid_q && mean_ready) begin
            mean_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        ERR: begin
          if (epoch_start) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready      = s_ready_q;
  assign mc_start     = mc_start_q;
  assign mc_eeg       = mc_eeg_q;
  assign mc_start_div = mc_start_div_q;
  assign mean_out     = mean_out_q;
  assign mean_valid   = mean_valid_q;
  assign busy         = (state_q != IDLE);
  assign err_timeout  = err_timeout_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_mean_window_ctrl.sv
// Directed bench for mean_window_ctrl with a behavioural mean stage
// (running sum, 8-bit count, completion BLANK_CYC+3 cycles after launch).
module tb_mean_window_ctrl;

  localparam int BLANK = 2;
  localparam int TOUT  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        epoch_start = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [17:0] s_eeg = '0;
  logic        mc_start;
  logic [17:0] mc_eeg;
  logic        mc_start_div;
  logic        mc_complete_div;
  logic [17:0] mc_mean;
  logic [7:0]  mc_count;
  logic [17:0] mean_out;
  logic        mean_valid;
  logic        mean_ready = 1'b0;
  logic        busy;
  logic        err_timeout;
  logic        err_count;

  int total = 0;
  int bad   = 0;

  mean_window_ctrl #(.WINDOW(256), .BLANK_CYC(BLANK), .TIMEOUT(TOUT)) dut (
    .clk(clk), .reset(reset), .epoch_start(epoch_start),
    .s_valid(s_valid), .s_ready(s_ready), .s_eeg(s_eeg),
    .mc_start(mc_start), .mc_eeg(mc_eeg), .mc_start_div(mc_start_div),
    .mc_complete_div(mc_complete_div), .mc_mean(mc_mean), .mc_count(mc_count),
    .mean_out(mean_out), .mean_valid(mean_valid), .mean_ready(mean_ready),
    .busy(busy), .err_timeout(err_timeout), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Mean stage model. mode 0: complete pulse at launch+BLANK+3;
  // mode 1: complete idle-high, low only between blank end and completion;
  // mode 2: never completes.
  int                 mode = 0;
  logic               m_clr = 1'b0;
  logic signed [31:0] m_sum;
  logic [7:0]         m_cnt;
  logic               m_act;
  int                 m_phase;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sum <= 0; m_cnt <= 0; m_act <= 1'b0; m_phase <= 0;
    end else begin
      if (m_clr) begin
        m_sum <= 0; m_cnt <= 0;
      end else if (mc_start) begin
        m_sum <= m_sum + 32'(signed'(mc_eeg));
        m_cnt <= m_cnt + 8'd1;
      end
      if (mc_start_div) begin
        m_act <= 1'b1; m_phase <= 1;
      end else if (m_act) begin
        if (m_phase >= BLANK + 3) m_act <= 1'b0;
        m_phase <= m_phase + 1;
      end
    end
  end

  always_comb begin
    mc_complete_div = 1'b0;
    case (mode)
      0: mc_complete_div = m_act && (m_phase == BLANK + 3);
      1: mc_complete_div = !(m_act && (m_phase > BLANK) && (m_phase < BLANK + 3));
      default: mc_complete_div = 1'b0;
    endcase
  end

  assign mc_mean  = m_sum[25:8];
  assign mc_count = m_cnt;

  // Event monitor, sampled on the falling edge.
  int          cyc = 0;
  int          n_start = 0;
  int          n_div = 0;
  int          last_start_cyc = 0;
  int          div_cyc = 0;
  int          mv_cyc = 0;
  int          to_cyc = 0;
  logic [17:0] last_eeg = '0;
  logic        mv_prev = 1'b0;
  logic        to_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mc_start) begin
      n_start <= n_start + 1; last_start_cyc <= cyc; last_eeg <= mc_eeg;
    end
    if (mc_start_div) begin
      n_div <= n_div + 1; div_cyc <= cyc;
    end
    if (mean_valid && !mv_prev) mv_cyc <= cyc;
    if (err_timeout && !to_prev) to_cyc <= cyc;
    mv_prev <= mean_valid;
    to_prev <= err_timeout;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_epoch();
    @(negedge clk); epoch_start = 1'b1;
    @(negedge clk); epoch_start = 1'b0;
  endtask

  task automatic clear_model();
    @(negedge clk); m_clr = 1'b1;
    @(negedge clk); m_clr = 1'b0;
  endtask

  // Offers n samples (even index a, odd index b); random 50% duty when duty=1.
  // Also checks that each transfer shows up as mc_start exactly one cycle later.
  task automatic feed(input int n, input logic [17:0] a, input logic [17:0] b,
                      input int duty, input string tag);
    int   sent = 0;
    int   guard = 0;
    int   cad_err = 0;
    logic prev_x = 1'b0;
    while (sent < n && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (mc_start !== prev_x) cad_err++;
      if (duty != 0 && $urandom_range(0, 1) == 0) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_eeg   = (sent % 2 == 1) ? b : a;
      end
      prev_x = s_valid && s_ready;
      if (prev_x) sent++;
    end
    @(negedge clk);
    if (mc_start !== prev_x) cad_err++;
    s_valid = 1'b0;
    check({tag, "_sent"}, sent, n);
    check({tag, "_cadence"}, cad_err, 0);
  endtask

  task automatic wait_mean(input string tag);
    int k = 0;
    while (!mean_valid && k < 200) begin
      @(negedge clk); k++;
    end
    check({tag, "_mean_valid_seen"}, mean_valid, 1);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk); mean_ready = 1'b1;
    @(negedge clk); mean_ready = 1'b0;
    check({tag, "_valid_dropped"}, mean_valid, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int ns0;
    int nd0;
    int stable;

    // Reset state
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_mc_start", mc_start, 0);
    check("rst_mean_valid", mean_valid, 0);
    check("rst_mean_out", mean_out, 0);
    check("rst_busy", busy, 0);
    check("rst_errs", {err_timeout, err_count}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: back-to-back window of 1.0
    ns0 = n_start; nd0 = n_div;
    pulse_epoch();
    check("t1_s_ready", s_ready, 1);
    check("t1_busy", busy, 1);
    feed(256, 18'h01000, 18'h01000, 0, "t1");
    wait_mean("t1");
    check("t1_nstart", n_start - ns0, 256);
    check("t1_ndiv", n_div - nd0, 1);
    check("t1_div_gap", div_cyc - last_start_cyc, 1);
    check("t1_err_count", err_count, 0);
    check("t1_mean", mean_out, 18'h01000);
    repeat (3) @(negedge clk);
    check("t1_valid_held", mean_valid, 1);
    handshake("t1");

    // 2: random duty, alternating +0.5 / -0.25 -> mean 0.125
    clear_model();
    ns0 = n_start; nd0 = n_div;
    pulse_epoch();
    feed(256, 18'h00800, 18'h3FC00, 1, "t2");
    wait_mean("t2");
    check("t2_nstart", n_start - ns0, 256);
    check("t2_ndiv", n_div - nd0, 1);
    check("t2_mean", mean_out, 18'h00200);
    check("t2_err_count", err_count, 0);
    handshake("t2");

    // 3: s_valid stays high after the window
    clear_model();
    ns0 = n_start;
    pulse_epoch();
    feed(256, 18'h00400, 18'h00400, 0, "t3");
    s_valid = 1'b1; s_eeg = 18'h3FFFF;
    repeat (4) @(negedge clk);
    check("t3_s_ready_low", s_ready, 0);
    s_valid = 1'b0;
    wait_mean("t3");
    check("t3_nstart", n_start - ns0, 256);
    check("t3_last_eeg", last_eeg, 18'h00400);
    check("t3_mean", mean_out, 18'h00400);
    handshake("t3");

    // 4: idle-high completion must not be captured during blanking
    clear_model();
    mode = 1;
    pulse_epoch();
    feed(256, 18'h00800, 18'h00800, 0, "t4");
    wait_mean("t4");
    @(negedge clk);
    check("t4_capture_lat", mv_cyc - div_cyc, BLANK + 4);
    check("t4_mean", mean_out, 18'h00800);
    handshake("t4");

    // 5: divider never completes
    clear_model();
    mode = 2;
    pulse_epoch();
    feed(256, 18'h00100, 18'h00100, 0, "t5");
    begin
      int k = 0;
      while (!err_timeout && k < 100) begin
        @(negedge clk); k++;
      end
    end
    @(negedge clk);
    check("t5_err_timeout", err_timeout, 1);
    check("t5_to_lat", to_cyc - div_cyc, BLANK + TOUT);
    check("t5_no_valid", mean_valid, 0);
    check("t5_busy_err", busy, 1);
    pulse_epoch();
    check("t5_back_idle", busy, 0);
    check("t5_sticky", err_timeout, 1);

    // 6: reset in the middle of a window, then a full window of -1.0
    mode = 0;
    clear_model();
    pulse_epoch();
    feed(100, 18'h3F000, 18'h3F000, 0, "t6a");
    #2 reset = 1'b1;
    #1;
    check("t6_rst_mc_start", mc_start, 0);
    check("t6_rst_s_ready", s_ready, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_err", err_timeout, 0);
    ns0 = n_start; nd0 = n_div;
    @(negedge clk); reset = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_no_strobes", (n_start - ns0) + (n_div - nd0), 0);
    pulse_epoch();
    feed(256, 18'h3F000, 18'h3F000, 0, "t6b");
    wait_mean("t6");
    check("t6_mean", mean_out, 18'h3F000);
    check("t6_errs", {err_timeout, err_count}, 0);
    handshake("t6");

    // 7: downstream stalls for 20 cycles; epoch_start during handshake ignored
    clear_model();
    pulse_epoch();
    feed(256, 18'h02000, 18'h02000, 0, "t7");
    wait_mean("t7");
    stable = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mean_valid !== 1'b1 || mean_out !== 18'h02000) stable = 0;
    end
    check("t7_stable", stable, 1);
    @(negedge clk); mean_ready = 1'b1; epoch_start = 1'b1;
    @(negedge clk); mean_ready = 1'b0; epoch_start = 1'b0;
    check("t7_valid_dropped", mean_valid, 0);
    check("t7_idle", busy, 0);
    @(negedge clk);
    check("t7_epoch_ignored", s_ready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
